// File: rtl/sn_stream_gen.sv
// Binary-to-stochastic encoder: bit-reversed counter compared per lane against offset-binary operands.
// Latency: first stream bit is registered one cycle after the accepted start; done pulses the cycle after the last bit.
// Backpressure: none; start is only honoured in IDLE, ignored (not queued) while busy.
module sn_stream_gen #(
    parameter int LANES    = 4,
    parameter int DW       = 4,
    parameter int LANE_OFS = 0
) (
    input  logic             i_clk_sng,
    input  logic             i_rst_sng,
    input  logic             i_start_sng,
    input  logic [DW-1:0]    i_x_sng [LANES],
    input  logic [DW-1:0]    i_len_sng,
    output logic             o_busy_sng,
    output logic             o_valid_sng,
    output logic [LANES-1:0] o_sn_bit_sng,
    output logic             o_done_sng
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // Inverting the sign bit maps two's complement onto 0..2^DW-1 offset binary.
    localparam logic [DW-1:0] SIGN_BIT = DW'(1) << (DW - 1);

    state_t             state, state_nx;
    logic [DW-1:0]      cnt, cnt_nx;
    logic [DW-1:0]      len, len_nx;
    logic [DW-1:0]      u [LANES];
    logic [DW-1:0]      u_nx [LANES];
    logic [DW-1:0]      ops [LANES];
    logic [DW-1:0]      idx;
    logic [LANES-1:0]   lane_bits;
    logic [LANES-1:0]   bits_nx;
    logic               valid_nx;
    logic               done_nx;

    function automatic logic [DW-1:0] bitrev(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        for (int j = 0; j < DW; j++) begin
            r[j] = v[DW-1-j];
        end
        return r;
    endfunction

    // Operand/index source: in IDLE the incoming operands at index 0 (so the first
    // bit is ready right after the start edge), otherwise the frozen operands at cnt+1.
    always_comb begin
        idx = '0;
        for (int k = 0; k < LANES; k++) begin
            ops[k] = u[k];
        end
        if (state == S_IDLE) begin
            for (int k = 0; k < LANES; k++) begin
                ops[k] = i_x_sng[k] ^ SIGN_BIT;
            end
        end else begin
            idx = cnt + DW'(1);
        end
    end

    // Per-lane comparison of the shared low-discrepancy sequence against the operand.
    always_comb begin
        lane_bits = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_bits[k] = (bitrev(idx + DW'(k * LANE_OFS)) < ops[k]);
        end
    end

    // Next-state and next-output logic for the IDLE/RUN/DONE burst framer.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        len_nx   = len;
        valid_nx = 1'b0;
        done_nx  = 1'b0;
        bits_nx  = '0;
        for (int k = 0; k < LANES; k++) begin
            u_nx[k] = u[k];
        end
        case (state)
            S_IDLE: begin
                if (i_start_sng) begin
                    state_nx = S_RUN;
                    cnt_nx   = '0;
                    len_nx   = i_len_sng;
                    valid_nx = 1'b1;
                    bits_nx  = lane_bits;
                    for (int k = 0; k < LANES; k++) begin
                        u_nx[k] = ops[k];
                    end
                end
            end
            S_RUN: begin
                // cnt wraps here only after the final index of a full-period burst.
                cnt_nx = cnt + DW'(1);
                if (cnt == len) begin
                    state_nx = S_DONE;
                    done_nx  = 1'b1;
                end else begin
                    valid_nx = 1'b1;
                    bits_nx  = lane_bits;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset truncates any burst without a done pulse.
    always_ff @(posedge i_clk_sng) begin
        if (i_rst_sng) begin
            state        <= S_IDLE;
            cnt          <= '0;
            len          <= '0;
            o_valid_sng  <= 1'b0;
            o_done_sng   <= 1'b0;
            o_sn_bit_sng <= '0;
            for (int k = 0; k < LANES; k++) begin
                u[k] <= '0;
            end
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            len          <= len_nx;
            o_valid_sng  <= valid_nx;
            o_done_sng   <= done_nx;
            o_sn_bit_sng <= bits_nx;
            for (int k = 0; k < LANES; k++) begin
                u[k] <= u_nx[k];
            end
        end
    end

    assign o_busy_sng = (state != S_IDLE);

endmodule

// File: tb/tb_sn_stream_gen.sv
// Bench for sn_stream_gen: two instances (lane offset 0 and 1) share stimulus.
// Expected bits per burst come from an arithmetic reference model pushed to a queue.
// A negedge monitor pops and compares whenever a DUT presents a bit or a done pulse.
module tb_sn_stream_gen;

    localparam int LANES = 4;
    localparam int DW    = 4;
    localparam int HALF  = 8;
    localparam int PER   = 16;

    typedef struct packed {
        logic       dn;
        logic [3:0] b0;
        logic [3:0] b1;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] x_in [LANES];
    logic [3:0] len_in;
    logic       busy0, valid0, done0;
    logic [3:0] sn0;
    logic       busy1, valid1, done1;
    logic [3:0] sn1;

    exp_t q[$];
    int   tests;
    int   errors;
    int   ones0 [LANES];
    int   ones1 [LANES];
    int   done_cnt;

    sn_stream_gen #(.LANES(LANES), .DW(DW), .LANE_OFS(0)) dut (
        .i_clk_sng(clk), .i_rst_sng(rst), .i_start_sng(start),
        .i_x_sng(x_in), .i_len_sng(len_in),
        .o_busy_sng(busy0), .o_valid_sng(valid0),
        .o_sn_bit_sng(sn0), .o_done_sng(done0)
    );

    sn_stream_gen #(.LANES(LANES), .DW(DW), .LANE_OFS(1)) dut1 (
        .i_clk_sng(clk), .i_rst_sng(rst), .i_start_sng(start),
        .i_x_sng(x_in), .i_len_sng(len_in),
        .o_busy_sng(busy1), .o_valid_sng(valid1),
        .o_sn_bit_sng(sn1), .o_done_sng(done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Bit reversal by repeated halving/doubling.
    function automatic int rev(input int v);
        int r = 0;
        int t = v;
        for (int j = 0; j < DW; j++) begin
            r = r * 2 + (t % 2);
            t = t / 2;
        end
        return r;
    endfunction

    // Reference model: the whole burst for both lane offsets, then the done marker.
    task automatic push_burst(input int xs [LANES], input int ln);
        exp_t e;
        for (int i = 0; i <= ln; i++) begin
            e = '0;
            for (int k = 0; k < LANES; k++) begin
                e.b0[k] = (rev(i % PER) < xs[k] + HALF);
                e.b1[k] = (rev((i + k) % PER) < xs[k] + HALF);
            end
            q.push_back(e);
        end
        e = '0;
        e.dn = 1'b1;
        q.push_back(e);
    endtask

    task automatic drive(input int xs [LANES], input int ln);
        for (int k = 0; k < LANES; k++) x_in[k] = 4'(xs[k]);
        len_in = 4'(ln);
    endtask

    task automatic scramble();
        for (int k = 0; k < LANES; k++) x_in[k] = 4'($urandom_range(0, 15));
        len_in = 4'($urandom_range(0, 15));
    endtask

    task automatic clear_counts();
        for (int k = 0; k < LANES; k++) begin
            ones0[k] = 0;
            ones1[k] = 0;
        end
        done_cnt = 0;
    endtask

    // One start pulse from IDLE; checks latency, busy length and a single done.
    task automatic burst(input int xs [LANES], input int ln, input bit mess);
        int n = 0;
        clear_counts();
        drive(xs, ln);
        start = 1'b1;
        push_burst(xs, ln);
        @(posedge clk); #1;
        start = 1'b0;
        chk("first_valid_latency", int'(valid0), 1);
        while (busy0 && n < 100) begin
            n++;
            if (mess) scramble();
            @(posedge clk); #1;
        end
        chk("busy_cycles", n, ln + 2);
        chk("done_pulses", done_cnt, 1);
    endtask

    // Monitor: pops the scoreboard whenever a DUT shows a bit or done.
    always @(negedge clk) begin
        exp_t e;
        if (valid0 || done0 || valid1 || done1) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                e = q.pop_front();
                chk("done_flag", int'(done0), int'(e.dn));
                chk("valid_flag", int'(valid0), int'(!e.dn));
                chk("ofs1_valid_flag", int'(valid1), int'(!e.dn));
                chk("ofs1_done_flag", int'(done1), int'(e.dn));
                chk("bits_ofs0", int'(sn0), int'(e.b0));
                chk("bits_ofs1", int'(sn1), int'(e.b1));
                if (done0) done_cnt++;
                if (valid0)
                    for (int k = 0; k < LANES; k++) ones0[k] += int'(sn0[k]);
                if (valid1)
                    for (int k = 0; k < LANES; k++) ones1[k] += int'(sn1[k]);
            end
        end else begin
            chk("idle_bits_zero", int'({sn0, sn1}), 0);
        end
    end

    initial begin
        int xs [LANES];
        int ln;
        int n;
        tests = 0;
        errors = 0;
        rst = 1'b1;
        start = 1'b0;
        for (int k = 0; k < LANES; k++) x_in[k] = 4'd0;
        len_in = 4'd0;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy0), 0);
        chk("reset_valid", int'(valid0), 0);
        chk("reset_done", int'(done0), 0);
        chk("reset_bits", int'(sn0), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Full period, extreme and mid operands.
        xs = '{-8, 0, 3, 7};
        burst(xs, 15, 1'b0);
        chk("ones_lane0_min", ones0[0], 0);
        chk("ones_lane1_zero", ones0[1], 8);
        chk("ones_lane2_three", ones0[2], 11);
        chk("ones_lane3_max", ones0[3], 15);

        // Half period of zeros: alternating pattern.
        xs = '{0, 0, 0, 0};
        burst(xs, 7, 1'b0);
        for (int k = 0; k < LANES; k++) chk("ones_half_period", ones0[k], 4);

        // Single-bit burst.
        xs = '{-7, 0, 0, 0};
        burst(xs, 0, 1'b0);
        chk("len0_lane0_one", ones0[0], 1);

        // Lane offset 1, full period of zeros.
        xs = '{0, 0, 0, 0};
        burst(xs, 15, 1'b1);
        for (int k = 0; k < LANES; k++) chk("ofs1_ones", ones1[k], 8);

        // Start held high: restarts only from IDLE, inputs scrambled mid-burst.
        start = 1'b1;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < LANES; k++) xs[k] = $urandom_range(0, 15) - HALF;
            ln = $urandom_range(0, 5);
            drive(xs, ln);
            push_burst(xs, ln);
            @(posedge clk); #1;
            for (int c = 1; c <= ln + 2; c++) begin
                scramble();
                @(posedge clk); #1;
                if (c == ln + 1) chk("held_done", int'(done0), 1);
                if (c == ln + 2) chk("held_idle_gap", int'(busy0), 0);
            end
        end
        start = 1'b0;
        @(posedge clk); #1;

        // Reset during RUN cycle 5.
        xs = '{1, -3, 5, 2};
        drive(xs, 15);
        start = 1'b1;
        push_burst(xs, 15);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrun_reset_valid", int'(valid0), 0);
        chk("midrun_reset_done", int'(done0), 0);
        chk("midrun_reset_busy", int'(busy0), 0);
        chk("midrun_reset_bits", int'(sn0), 0);
        q.delete();
        rst = 1'b0;
        @(posedge clk); #1;
        burst(xs, 15, 1'b0);

        // Random bursts.
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < LANES; k++) xs[k] = $urandom_range(0, 15) - HALF;
            burst(xs, $urandom_range(0, 15), 1'b1);
        end

        n = 0;
        while (q.size() != 0 && n < 50) begin
            n++;
            @(posedge clk); #1;
        end
        chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
